// File: rtl/writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : writeback_pipe -- dual 7-stage result staging, write-back, forwarding
// Revision : 1.0  initial release
// ============================================================================
module writeback_pipe #(
   parameter int DEPTH = 7,
   parameter int WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid_even,
   input  logic                 issue_valid_odd,
   input  logic [0:6]           issue_addr_even,
   input  logic [0:6]           issue_addr_odd,
   input  logic [2:0]           issue_lat_even,
   input  logic [2:0]           issue_lat_odd,
   input  logic                 res_valid_even,
   input  logic                 res_valid_odd,
   input  logic [2:0]           res_lat_even,
   input  logic [2:0]           res_lat_odd,
   input  logic [0:WIDTH-1]     res_data_even,
   input  logic [0:WIDTH-1]     res_data_odd,
   output logic [0:6]           rt_addr_even,
   output logic [0:6]           rt_addr_odd,
   output logic [0:WIDTH-1]     rt_even,
   output logic [0:WIDTH-1]     rt_odd,
   output logic                 reg_write_even,
   output logic                 reg_write_odd,
   input  logic [0:41]          q_addr,
   output logic [0:5]           q_hit,
   output logic [0:5]           q_pend,
   output logic [0:6*WIDTH-1]   q_data,
   output logic                 err
);

   localparam int c_NQ = 6;

   // Index 0 is the even pipe, index 1 the odd pipe; stage s lives at [s-1].
   logic             w_iss_v    [2];
   logic [0:6]       w_iss_addr [2];
   logic [2:0]       w_iss_lat  [2];
   logic             w_res_v    [2];
   logic [2:0]       w_res_lat  [2];
   logic [0:WIDTH-1] w_res_data [2];

   logic             r_valid [2][DEPTH];
   logic [0:6]       r_addr  [2][DEPTH];
   logic [2:0]       r_lat   [2][DEPTH];
   logic             r_ready [2][DEPTH];
   logic [0:WIDTH-1] r_data  [2][DEPTH];
   logic             r_err;

   logic             w_cap     [2];
   logic             w_cap_err [2];
   logic             w_miss    [2];
   logic             w_fnd;
   logic             w_rdy;
   logic [0:WIDTH-1] w_fdat;

   assign w_iss_v[0]    = issue_valid_even;
   assign w_iss_v[1]    = issue_valid_odd;
   assign w_iss_addr[0] = issue_addr_even;
   assign w_iss_addr[1] = issue_addr_odd;
   assign w_iss_lat[0]  = issue_lat_even;
   assign w_iss_lat[1]  = issue_lat_odd;
   assign w_res_v[0]    = res_valid_even;
   assign w_res_v[1]    = res_valid_odd;
   assign w_res_lat[0]  = res_lat_even;
   assign w_res_lat[1]  = res_lat_odd;
   assign w_res_data[0] = res_data_even;
   assign w_res_data[1] = res_data_odd;

   function automatic logic [2:0] clamp_lat(input logic [2:0] lat);
      return (lat == 3'd0 || lat == 3'd7) ? 3'd6 : lat;
   endfunction

   // A result is accepted only by a waiting entry of matching latency in stage res_lat.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_cap[p] = 1'b0;
         for (int s = 0; s < DEPTH-1; s++) begin
            if (w_res_v[p] && int'(w_res_lat[p]) == s + 1 && r_valid[p][s] &&
                r_lat[p][s] == w_res_lat[p] && !r_ready[p][s])
               w_cap[p] = 1'b1;
         end
         w_cap_err[p] = w_res_v[p] && !w_cap[p];
         w_miss[p]    = r_valid[p][DEPTH-2] && !r_ready[p][DEPTH-2] &&
                        !(w_cap[p] && int'(w_res_lat[p]) == DEPTH-1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < DEPTH; s++) begin
               r_valid[p][s] <= 1'b0;
               r_addr[p][s]  <= '0;
               r_lat[p][s]   <= '0;
               r_ready[p][s] <= 1'b0;
               r_data[p][s]  <= '0;
            end
         end
         r_err <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            r_valid[p][0] <= w_iss_v[p];
            r_addr[p][0]  <= w_iss_v[p] ? w_iss_addr[p] : 7'd0;
            r_lat[p][0]   <= w_iss_v[p] ? clamp_lat(w_iss_lat[p]) : 3'd0;
            r_ready[p][0] <= 1'b0;
            r_data[p][0]  <= '0;
            for (int s = 1; s < DEPTH; s++) begin
               r_valid[p][s] <= r_valid[p][s-1];
               r_addr[p][s]  <= r_addr[p][s-1];
               r_lat[p][s]   <= r_lat[p][s-1];
               if (w_cap[p] && int'(w_res_lat[p]) == s) begin
                  r_ready[p][s] <= 1'b1;
                  r_data[p][s]  <= w_res_data[p];
               end else begin
                  r_ready[p][s] <= r_ready[p][s-1];
                  r_data[p][s]  <= r_data[p][s-1];
               end
            end
         end
         r_err <= r_err | w_cap_err[0] | w_cap_err[1] | w_miss[0] | w_miss[1];
      end
   end

   assign err            = r_err;
   assign reg_write_even = r_valid[0][DEPTH-1];
   assign reg_write_odd  = r_valid[1][DEPTH-1];
   assign rt_addr_even   = r_valid[0][DEPTH-1] ? r_addr[0][DEPTH-1] : 7'd0;
   assign rt_addr_odd    = r_valid[1][DEPTH-1] ? r_addr[1][DEPTH-1] : 7'd0;
   assign rt_even        = (r_valid[0][DEPTH-1] && r_ready[0][DEPTH-1]) ? r_data[0][DEPTH-1] : '0;
   assign rt_odd         = (r_valid[1][DEPTH-1] && r_ready[1][DEPTH-1]) ? r_data[1][DEPTH-1] : '0;

   // Scan oldest to youngest, even before odd, so the last match is the winner.
   always_comb begin
      q_hit  = '0;
      q_pend = '0;
      q_data = '0;
      w_fnd  = 1'b0;
      w_rdy  = 1'b0;
      w_fdat = '0;
      for (int q = 0; q < c_NQ; q++) begin
         w_fnd  = 1'b0;
         w_rdy  = 1'b0;
         w_fdat = '0;
         for (int s = DEPTH-1; s >= 0; s--) begin
            for (int p = 0; p < 2; p++) begin
               if (r_valid[p][s] && r_addr[p][s] == q_addr[7*q +: 7]) begin
                  w_fnd  = 1'b1;
                  w_rdy  = r_ready[p][s];
                  w_fdat = r_data[p][s];
               end
            end
         end
         q_hit[q]                  = w_fnd && w_rdy;
         q_pend[q]                 = w_fnd && !w_rdy;
         q_data[WIDTH*q +: WIDTH]  = (w_fnd && w_rdy) ? w_fdat : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_pipe -- directed self-checking bench for writeback_pipe
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_pipe;

   localparam int W = 128;
   localparam logic [0:W-1] DA   = {16'h000A, 112'h0};
   localparam logic [0:W-1] DB   = {16'h000B, 112'h0};
   localparam logic [0:W-1] DC   = {16'h000C, 112'h5};
   localparam logic [0:W-1] DE   = {16'h000E, 112'h3};
   localparam logic [0:W-1] DBAD = {16'hDEAD, 112'h1};
   localparam logic [0:W-1] D1   = {16'h0001, 112'h11};
   localparam logic [0:W-1] D2   = {16'h0002, 112'h22};
   localparam logic [0:W-1] D3   = {16'h0003, 112'h33};
   localparam logic [0:W-1] D4   = {16'h0004, 112'h44};
   localparam logic [0:6]   NA   = 7'd127;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           issue_valid_even, issue_valid_odd;
   logic [0:6]     issue_addr_even, issue_addr_odd;
   logic [2:0]     issue_lat_even, issue_lat_odd;
   logic           res_valid_even, res_valid_odd;
   logic [2:0]     res_lat_even, res_lat_odd;
   logic [0:W-1]   res_data_even, res_data_odd;
   logic [0:6]     rt_addr_even, rt_addr_odd;
   logic [0:W-1]   rt_even, rt_odd;
   logic           reg_write_even, reg_write_odd;
   logic [0:41]    q_addr;
   logic [0:5]     q_hit, q_pend;
   logic [0:6*W-1] q_data;
   logic           err;

   int errors = 0;
   int checks = 0;

   writeback_pipe #(.DEPTH(7), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .issue_valid_even(issue_valid_even), .issue_valid_odd(issue_valid_odd),
      .issue_addr_even(issue_addr_even), .issue_addr_odd(issue_addr_odd),
      .issue_lat_even(issue_lat_even), .issue_lat_odd(issue_lat_odd),
      .res_valid_even(res_valid_even), .res_valid_odd(res_valid_odd),
      .res_lat_even(res_lat_even), .res_lat_odd(res_lat_odd),
      .res_data_even(res_data_even), .res_data_odd(res_data_odd),
      .rt_addr_even(rt_addr_even), .rt_addr_odd(rt_addr_odd),
      .rt_even(rt_even), .rt_odd(rt_odd),
      .reg_write_even(reg_write_even), .reg_write_odd(reg_write_odd),
      .q_addr(q_addr), .q_hit(q_hit), .q_pend(q_pend), .q_data(q_data),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      issue_valid_even = 1'b0; issue_valid_odd = 1'b0;
      issue_addr_even  = '0;   issue_addr_odd  = '0;
      issue_lat_even   = '0;   issue_lat_odd   = '0;
      res_valid_even   = 1'b0; res_valid_odd   = 1'b0;
      res_lat_even     = '0;   res_lat_odd     = '0;
      res_data_even    = '0;   res_data_odd    = '0;
      q_addr           = {6{NA}};
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      #1;
      checks++;
      if ({reg_write_even, reg_write_odd, rt_addr_even, rt_addr_odd, err, q_hit, q_pend} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got %0h expected 0",
                  {reg_write_even, reg_write_odd, rt_addr_even, rt_addr_odd, err, q_hit, q_pend});
      end
      tick();
      reset = 1'b1;
      q_addr = {7'd5, {5{NA}}};
      issue_valid_even = 1'b1; issue_addr_even = 7'd5; issue_lat_even = 3'd2;
      tick();
      issue_valid_even = 1'b0;
      tick();
      res_valid_even = 1'b1; res_lat_even = 3'd2; res_data_even = DA;
      tick();
      res_valid_even = 1'b0;
      checks++;
      if (q_hit[0] !== 1'b1 || q_data[0 +: W] !== DA) begin
         errors++;
         $display("FAIL reset_prefwd: got hit=%0b data=%0h expected hit=1 data=%0h", q_hit[0], q_data[0 +: W], DA);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({reg_write_even, reg_write_odd, rt_addr_even, rt_addr_odd, err, q_hit, q_pend} !== '0) begin
         errors++;
         $display("FAIL reset_async_ctrl: got %0h expected 0",
                  {reg_write_even, reg_write_odd, rt_addr_even, rt_addr_odd, err, q_hit, q_pend});
      end
      checks++;
      if ({rt_even, rt_odd, q_data} !== '0) begin
         errors++;
         $display("FAIL reset_async_data: got nonzero rt_even=%0h q_data0=%0h expected 0", rt_even, q_data[0 +: W]);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (reg_write_even !== 1'b0 || q_data[0 +: W] !== '0) begin
            errors++;
            $display("FAIL reset_held: got rw=%0b data=%0h expected 0", reg_write_even, q_data[0 +: W]);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (reg_write_even !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped: got rw=%0b err=%0b expected 0 0", reg_write_even, err);
         end
      end
   endtask

   task automatic test_writeback;
      do_reset();
      issue_valid_even = 1'b1; issue_addr_even = 7'd5; issue_lat_even = 3'd2;
      tick();
      issue_valid_even = 1'b0;
      tick();
      res_valid_even = 1'b1; res_lat_even = 3'd2; res_data_even = DA;
      tick();
      res_valid_even = 1'b0;
      for (int e = 2; e <= 8; e++) begin
         checks++;
         if (reg_write_even !== (e == 6)) begin
            errors++;
            $display("FAIL wb_enable_E%0d: got %0b expected %0b", e, reg_write_even, (e == 6));
         end
         if (e == 6) begin
            checks++;
            if (rt_addr_even !== 7'd5 || rt_even !== DA) begin
               errors++;
               $display("FAIL wb_data: got addr=%0d data=%0h expected addr=5 data=%0h", rt_addr_even, rt_even, DA);
            end
         end
         tick();
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL wb_err: got %0b expected 0", err);
      end
   endtask

   task automatic test_forward;
      do_reset();
      q_addr = {NA, 7'd7, {4{NA}}};
      #1;
      checks++;
      if (q_hit[1] !== 1'b0 || q_pend[1] !== 1'b0) begin
         errors++;
         $display("FAIL fwd_empty: got hit=%0b pend=%0b expected 0 0", q_hit[1], q_pend[1]);
      end
      issue_valid_odd = 1'b1; issue_addr_odd = 7'd7; issue_lat_odd = 3'd6;
      tick();
      issue_valid_odd = 1'b0;
      for (int s = 1; s <= 6; s++) begin
         checks++;
         if (q_pend[1] !== 1'b1 || q_hit[1] !== 1'b0 || q_data[W +: W] !== '0) begin
            errors++;
            $display("FAIL fwd_pend_s%0d: got pend=%0b hit=%0b expected pend=1 hit=0", s, q_pend[1], q_hit[1]);
         end
         if (s == 6) begin
            res_valid_odd = 1'b1; res_lat_odd = 3'd6; res_data_odd = DB;
         end
         tick();
      end
      res_valid_odd = 1'b0;
      checks++;
      if (q_hit[1] !== 1'b1 || q_pend[1] !== 1'b0 || q_data[W +: W] !== DB) begin
         errors++;
         $display("FAIL fwd_hit_s7: got hit=%0b pend=%0b data=%0h expected 1 0 %0h", q_hit[1], q_pend[1], q_data[W +: W], DB);
      end
      checks++;
      if (reg_write_odd !== 1'b1 || rt_addr_odd !== 7'd7 || rt_odd !== DB) begin
         errors++;
         $display("FAIL fwd_wb_odd: got rw=%0b addr=%0d data=%0h expected 1 7 %0h", reg_write_odd, rt_addr_odd, rt_odd, DB);
      end
      tick();
      checks++;
      if (q_hit[1] !== 1'b0 || reg_write_odd !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL fwd_retired: got hit=%0b rw=%0b err=%0b expected 0 0 0", q_hit[1], reg_write_odd, err);
      end
   endtask

   task automatic test_priority;
      do_reset();
      q_addr = {7'd9, {4{NA}}, 7'd9};
      issue_valid_even = 1'b1; issue_addr_even = 7'd9; issue_lat_even = 3'd1;
      tick();                                  // E0
      issue_valid_even = 1'b0;
      res_valid_even = 1'b1; res_lat_even = 3'd1; res_data_even = D1;
      tick();                                  // E1
      res_valid_even = 1'b0;
      checks++;
      if (q_hit[0] !== 1'b1 || q_data[0 +: W] !== D1) begin
         errors++;
         $display("FAIL prio_first: got hit=%0b data=%0h expected 1 %0h", q_hit[0], q_data[0 +: W], D1);
      end
      issue_valid_even = 1'b1; issue_addr_even = 7'd9; issue_lat_even = 3'd1;
      tick();                                  // E2
      issue_valid_even = 1'b0;
      checks++;
      if (q_pend[0] !== 1'b1 || q_hit[0] !== 1'b0 || q_data[0 +: W] !== '0) begin
         errors++;
         $display("FAIL prio_young_pend: got pend=%0b hit=%0b expected 1 0", q_pend[0], q_hit[0]);
      end
      res_valid_even = 1'b1; res_lat_even = 3'd1; res_data_even = D2;
      tick();                                  // E3
      res_valid_even = 1'b0;
      checks++;
      if (q_hit[0] !== 1'b1 || q_data[0 +: W] !== D2) begin
         errors++;
         $display("FAIL prio_second: got hit=%0b data=%0h expected 1 %0h", q_hit[0], q_data[0 +: W], D2);
      end
      issue_valid_even = 1'b1; issue_addr_even = 7'd9; issue_lat_even = 3'd1;
      issue_valid_odd  = 1'b1; issue_addr_odd  = 7'd9; issue_lat_odd  = 3'd1;
      tick();                                  // E4
      issue_valid_even = 1'b0; issue_valid_odd = 1'b0;
      checks++;
      if (q_pend[5] !== 1'b1 || q_hit[5] !== 1'b0) begin
         errors++;
         $display("FAIL prio_pair_pend: got pend=%0b hit=%0b expected 1 0", q_pend[5], q_hit[5]);
      end
      res_valid_even = 1'b1; res_lat_even = 3'd1; res_data_even = D3;
      res_valid_odd  = 1'b1; res_lat_odd  = 3'd1; res_data_odd  = D4;
      tick();                                  // E5
      res_valid_even = 1'b0; res_valid_odd = 1'b0;
      checks++;
      if (q_hit[0] !== 1'b1 || q_data[0 +: W] !== D4 || q_hit[5] !== 1'b1 || q_data[5*W +: W] !== D4) begin
         errors++;
         $display("FAIL prio_odd_wins: got q0=%0h q5=%0h expected %0h", q_data[0 +: W], q_data[5*W +: W], D4);
      end
      tick();                                  // E6
      checks++;
      if (reg_write_even !== 1'b1 || rt_even !== D1 || reg_write_odd !== 1'b0) begin
         errors++;
         $display("FAIL prio_wb_first: got rwe=%0b data=%0h rwo=%0b expected 1 %0h 0", reg_write_even, rt_even, reg_write_odd, D1);
      end
      for (int i = 0; i < 4; i++) tick();      // E10
      checks++;
      if (reg_write_even !== 1'b1 || reg_write_odd !== 1'b1 || rt_addr_even !== 7'd9 ||
          rt_addr_odd !== 7'd9 || rt_even !== D3 || rt_odd !== D4) begin
         errors++;
         $display("FAIL prio_wb_pair: got rwe=%0b rwo=%0b de=%0h do=%0h expected 1 1 %0h %0h",
                  reg_write_even, reg_write_odd, rt_even, rt_odd, D3, D4);
      end
      checks++;
      if (q_data[0 +: W] !== D4 || err !== 1'b0) begin
         errors++;
         $display("FAIL prio_s7_fwd: got data=%0h err=%0b expected %0h 0", q_data[0 +: W], err, D4);
      end
   endtask

   task automatic test_clamp;
      do_reset();
      issue_valid_even = 1'b1; issue_addr_even = 7'd20; issue_lat_even = 3'd7;
      tick();                                  // E0
      issue_valid_even = 1'b0;
      for (int i = 0; i < 5; i++) tick();      // E5, stage 6
      res_valid_even = 1'b1; res_lat_even = 3'd6; res_data_even = DC;
      tick();                                  // E6
      res_valid_even = 1'b0;
      checks++;
      if (reg_write_even !== 1'b1 || rt_addr_even !== 7'd20 || rt_even !== DC || err !== 1'b0) begin
         errors++;
         $display("FAIL clamp_lat7: got rw=%0b addr=%0d data=%0h err=%0b expected 1 20 %0h 0",
                  reg_write_even, rt_addr_even, rt_even, err, DC);
      end
   endtask

   task automatic test_errors;
      do_reset();
      issue_valid_even = 1'b1; issue_addr_even = 7'd3; issue_lat_even = 3'd3;
      tick();                                  // E0
      issue_valid_even = 1'b0;
      tick();                                  // E1
      tick();                                  // E2, stage 3
      res_valid_even = 1'b1; res_lat_even = 3'd3; res_data_even = DE;
      tick();                                  // E3, stage 4 ready
      res_valid_even = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got %0b expected 0", err);
      end
      res_valid_even = 1'b1; res_lat_even = 3'd4; res_data_even = DBAD;
      tick();                                  // E4
      res_valid_even = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_spurious: got %0b expected 1", err);
      end
      tick();
      tick();                                  // E6
      checks++;
      if (reg_write_even !== 1'b1 || rt_addr_even !== 7'd3 || rt_even !== DE) begin
         errors++;
         $display("FAIL err_wb_intact: got rw=%0b addr=%0d data=%0h expected 1 3 %0h", reg_write_even, rt_addr_even, rt_even, DE);
      end
      tick();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %0b expected 1", err);
      end
      do_reset();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got %0b expected 0", err);
      end
      issue_valid_odd = 1'b1; issue_addr_odd = 7'd11; issue_lat_odd = 3'd2;
      tick();                                  // E0
      issue_valid_odd = 1'b0;
      for (int i = 0; i < 5; i++) tick();      // E5
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL miss_early: got %0b expected 0", err);
      end
      tick();                                  // E6
      checks++;
      if (reg_write_odd !== 1'b1 || rt_addr_odd !== 7'd11 || rt_odd !== '0) begin
         errors++;
         $display("FAIL miss_wb_zero: got rw=%0b addr=%0d data=%0h expected 1 11 0", reg_write_odd, rt_addr_odd, rt_odd);
      end
      tick();                                  // E7
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL miss_err: got %0b expected 1", err);
      end
   endtask

   initial begin
      test_reset();
      test_writeback();
      test_forward();
      test_priority();
      test_clamp();
      test_errors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/writeback_pipe.md
# writeback_pipe

Dual-pipe result staging and forwarding block between the even/odd execution units and `RegisterTable`. Each issued instruction occupies a 7-stage shift entry in its pipe. The unit result is captured at the stage equal to its latency. Stage 7 drives the `rt_addr_*` / `rt_*` / `reg_write_*` write port of `RegisterTable`, and the block answers six operand-forwarding queries from all in-flight, result-ready entries.

## Interface
Parameters:
- `DEPTH`, 7, pipeline stages per pipe; stage `DEPTH` feeds the register file.
- `WIDTH`, 128, result width; big-endian numbering `[0:WIDTH-1]`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `issue_valid_even` / `issue_valid_odd`  in  1  instruction issued into the pipe this cycle.
- `issue_addr_even` / `issue_addr_odd`  in  [0:6]  destination register.
- `issue_lat_even` / `issue_lat_odd`  in  [2:0]  unit latency, legal 1..6; 0 or 7 is treated as 6.
- `res_valid_even` / `res_valid_odd`  in  1  unit result present this cycle.
- `res_lat_even` / `res_lat_odd`  in  [2:0]  latency tag of the presented result.
- `res_data_even` / `res_data_odd`  in  [0:127]  result value.
- `rt_addr_even` / `rt_addr_odd`  out  [0:6]  register-file write address.
- `rt_even` / `rt_odd`  out  [0:127]  register-file write data.
- `reg_write_even` / `reg_write_odd`  out  1  register-file write enable.
- `q_addr`  in  [0:41]  six packed 7-bit query addresses: even ra, rb, rc, then odd ra, rb, rt_st.
- `q_hit`  out  [0:5]  matching in-flight entry found with data ready.
- `q_pend`  out  [0:5]  youngest matching entry has no data yet; the issue stage must stall.
- `q_data`  out  [0:767]  six packed 128-bit forwarded values; zero when no hit.
- `err`  out  1  sticky protocol error.

## Operation
- Entry per stage s (1..7) per pipe: `valid`, `addr`, `lat`, `ready`, `data`.
- Issue: on a clock edge with `issue_valid_*`=1, stage 1 loads `valid`=1, `addr`, clamped `lat`, `ready`=0, `data`=0. Otherwise stage 1 loads `valid`=0.
- Every edge, stage s moves to s+1 unconditionally. There is no stall or back-pressure. The stage-7 entry retires.
- Result capture: when `res_valid_*`=1, the entry in stage `res_lat` of that pipe is checked. If it is valid with `lat`==`res_lat` and `ready`=0, it moves into stage `res_lat`+1 with `ready`=1 and `data`=`res_data`. Otherwise `err` is set and no entry is modified.
- Missing result: an entry that reaches stage 7 with `ready`=0 sets `err` and writes back 0.
- Write port: `rt_addr_*`, `rt_*`, `reg_write_*` are combinational from the stage-7 entry. `reg_write_*`=`valid`; addr and data are 0 when not valid.
- Forwarding, per query q: candidates are valid entries in stages 1..7 of both pipes with `addr`==`q_addr[q]`.
  - The youngest candidate wins: lowest stage number first. At equal stage, the odd pipe wins because it is later in program order.
  - Winner `ready`=1: `q_hit`=1 and `q_data`=winner `data`.
  - Winner `ready`=0: `q_pend`=1, `q_hit`=0, `q_data`=0.
  - No candidate: all three outputs are 0, and the operand comes from `RegisterTable`.
- A stage-7 entry still forwards in the same cycle it writes back. This covers the `RegisterTable` read-during-write case.
- `err` clears only on reset.

## Timing
- Reset low, asynchronously: all `valid`, `ready`, `data` cleared and `err`=0. All outputs read 0 immediately.
  - Reset asserted mid-operation drops every in-flight entry; no write-back occurs.
  - After release, the first issue edge behaves normally.
- Issue sampled at edge E0. The entry sits in stage s during the cycle after edge E(s-1).
- The result for latency L is presented during the cycle the entry is in stage L and captured at edge EL.
- `reg_write` is high during the cycle after E6. `RegisterTable` writes at E7, which is the end of the 8th cycle counting the issue cycle.
- Forwarding is combinational from state: zero latency, and it is valid in the same cycle as `q_addr`.
- Simultaneous issue on both pipes to the same `addr` is legal. The odd pipe wins forwarding; both pipes write back, so `RegisterTable` ordering applies.
- Issue and result in the same cycle are independent; the new entry in stage 1 never captures a result.

## Test plan
- Reset check: issue even addr 5, lat 2, then pull `reset` low at cycle 3. Required: `reg_write_even` stays 0 thereafter, and all outputs read 0 while reset is low.
- Even write-back: issue even addr 5, lat 2 at E0, with the result `000A…0` (128-bit) presented while the entry is in stage 2. Required: `reg_write_even`=1, `rt_addr_even`=5, `rt_even`=`000A…0` in exactly one cycle, after E6. `err`=0.
- Forwarding and pending: issue odd addr 7, lat 6, and query `q_addr` even-rb=7. Required: `q_pend[1]`=1 while the entry is in stages 1–6. After the result `000B…0` is captured, `q_hit[1]`=1 and `q_data` slot 1=`000B…0` in the stage-7 cycle.
- Priority: issue even addr 9 at E0, then even addr 9 at E2, then even and odd both to addr 9 at E4, all lat 1 with distinct data. Required: a query on 9 after E5 returns the odd E4 data.
- Protocol error: `res_valid_even`=1 with `res_lat_even`=4 when no entry in stage 4 has lat 4. Required: `err`=1 sticky and all other write-backs unchanged. A separate issue whose result is never presented also sets `err` and writes back 0.
